// File: rtl/alu_seq_if.sv
// Controller <-> ALU bus: op request (start/opcode/a/b) and status/result return.
//   master: controller side, drives start/opcode/a/b, observes busy/done/result/flags
//   slave : ALU side, observes the request, drives busy/done/result/flags
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;

    modport master (
        output start, opcode, a, b,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, opcode, a, b,
        output busy, done, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered parametrised ALU with an iterative shift-add unsigned multiply.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : alu_seq_if.slave
//            start/opcode/a/b in; busy/done/result/flags out (all registered)
//   flags  : {Z,C,F,N,L} in bits [4:0], held until the next done pulse
// Single-cycle ops register their result at the accepting edge (done on the next cycle).
// MUL loads the counter with WIDTH at the accepting edge and retires one multiplier bit
// per edge; done rises on the edge where the counter reaches 0.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    prod_q, prod_d;

    // Single-cycle ALU path, evaluated on the live request inputs
    logic [WIDTH:0]   sum_x, diff_x;
    logic [WIDTH-1:0] alu_r;
    logic [4:0]       alu_f;
    logic             f_z, f_c, f_f, f_n, f_l;

    // Multiply step: prod holds {accumulator, remaining multiplier bits}
    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    prod_step;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;

    // Combinational result/flags for the non-MUL ops
    always_comb begin
        sum_x  = {1'b0, bus.a} + {1'b0, bus.b};
        diff_x = {1'b0, bus.a} - {1'b0, bus.b};
        alu_r  = '0;
        f_c    = 1'b0;
        f_f    = 1'b0;
        f_n    = 1'b0;
        f_l    = 1'b0;
        case (bus.opcode)
            OP_ADDU: begin
                alu_r = sum_x[MSB:0];
                f_c   = sum_x[WIDTH];
            end
            OP_ADD: begin
                alu_r = sum_x[MSB:0];
                f_f   = (bus.a[MSB] == bus.b[MSB]) && (alu_r[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_r = diff_x[MSB:0];
                f_c   = diff_x[WIDTH];
                f_f   = (bus.a[MSB] != bus.b[MSB]) && (alu_r[MSB] != bus.a[MSB]);
            end
            OP_CMP: begin
                f_l = bus.a < bus.b;
                f_n = $signed(bus.a) < $signed(bus.b);
            end
            OP_AND: begin
                alu_r = bus.a & bus.b;
                f_n   = alu_r[MSB];
            end
            OP_OR: begin
                alu_r = bus.a | bus.b;
                f_n   = alu_r[MSB];
            end
            OP_XOR: begin
                alu_r = bus.a ^ bus.b;
                f_n   = alu_r[MSB];
            end
            default: ;
        endcase
        // CMP reports equality in Z instead of a zero result
        f_z   = (bus.opcode == OP_CMP) ? (bus.a == bus.b) : (alu_r == '0);
        alu_f = {f_z, f_c, f_f, f_n, f_l};
    end

    // One shift-add iteration
    always_comb begin
        mul_sum   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {mul_sum, prod_q[MSB:1]};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    if (bus.opcode == OP_MUL) begin
                        prod_d  = {{WIDTH{1'b0}}, bus.b};
                        cnt_d   = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = MUL;
                    end else begin
                        result_d = alu_r;
                        flags_d  = alu_f;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = prod_step[MSB:0];
                    flags_d  = {prod_step[MSB:0] == '0, prod_step[PW-1:WIDTH] != '0, 3'b000};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=16): hand-computed vectors for every op,
// MUL latency/busy, start-while-busy, start-on-done and mid-multiply reset.
module tb_alu_seq;
    localparam int unsigned W = 16;

    localparam logic [2:0] ADDU = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] CMP  = 3'b011;
    localparam logic [2:0] AND_ = 3'b100;
    localparam logic [2:0] OR_  = 3'b101;
    localparam logic [2:0] XOR_ = 3'b110;
    localparam logic [2:0] MUL  = 3'b111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start  = st;
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
    endtask

    // Single-cycle op: done the cycle after the accepting edge, then drops
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic [4:0] ef);
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, op, '0, '0);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_res"}, 32'(bus.result), 32'(er));
        check({tag, "_flg"}, 32'(bus.flags), 32'(ef));
        step();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    // Steps until done; n = edges after the accepting edge, nb = cycles with busy low before done
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!bus.done && n < 200) begin
            if (!bus.busy) nb++;
            step();
            n++;
        end
    endtask

    initial begin
        int n, nb, dones;
        drive(1'b0, ADDU, '0, '0);
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", 32'(bus.result), 32'd0);
        check("rst_flg", 32'(bus.flags), 32'd0);

        run_op("addu_wrap", ADDU, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000);
        run_op("addu", ADDU, 16'h1234, 16'h1111, 16'h2345, 5'b00000);
        run_op("add_ovf", ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100);
        run_op("sub_brw", SUB, 16'h0003, 16'h0005, 16'hFFFE, 5'b01000);
        run_op("sub_ovf", SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100);
        run_op("cmp_neg", CMP, 16'hFFFE, 16'h0002, 16'h0000, 5'b00010);
        run_op("cmp_eq", CMP, 16'h0005, 16'h0005, 16'h0000, 5'b10000);
        run_op("cmp_lt", CMP, 16'h0001, 16'h0002, 16'h0000, 5'b00011);
        run_op("and", AND_, 16'hF0F0, 16'hFF00, 16'hF000, 5'b00010);
        run_op("or", OR_, 16'hF0F0, 16'hFF00, 16'hFFF0, 5'b00010);
        run_op("xor", XOR_, 16'hF0F0, 16'hF0F0, 16'h0000, 5'b10000);

        // MUL with truncation; operands changed after acceptance must not matter
        drive(1'b1, MUL, 16'h0100, 16'h0100);
        step();
        drive(1'b0, ADDU, 16'h1111, 16'h2222);
        check("mul1_busy", 32'(bus.busy), 32'd1);
        wait_done(n, nb);
        check("mul1_lat", 32'(n), 32'd16);
        check("mul1_busylo", 32'(nb), 32'd0);
        check("mul1_res", 32'(bus.result), 32'h0000);
        check("mul1_flg", 32'(bus.flags), 32'(5'b11000));
        check("mul1_busy_end", 32'(bus.busy), 32'd0);
        step();
        check("mul1_pulse", 32'(bus.done), 32'd0);

        // MUL with an AND start pulsed mid-flight (ignored), then start on the done cycle
        drive(1'b1, MUL, 16'd300, 16'd7);
        step();
        drive(1'b0, MUL, '0, '0);
        step();
        step();
        drive(1'b1, AND_, 16'h0000, 16'h0000);
        step();
        drive(1'b0, ADDU, '0, '0);
        check("ign_done", 32'(bus.done), 32'd0);
        check("ign_busy", 32'(bus.busy), 32'd1);
        wait_done(n, nb);
        check("mul2_lat", 32'(n + 3), 32'd16);
        check("mul2_res", 32'(bus.result), 32'd2100);
        check("mul2_flg", 32'(bus.flags), 32'd0);
        drive(1'b1, ADDU, 16'h0001, 16'h0002);
        step();
        check("b2b_done", 32'(bus.done), 32'd1);
        check("b2b_res", 32'(bus.result), 32'h0003);
        drive(1'b1, SUB, 16'h0000, 16'h0001);
        step();
        check("b2b2_done", 32'(bus.done), 32'd1);
        check("b2b2_res", 32'(bus.result), 32'hFFFF);
        check("b2b2_flg", 32'(bus.flags), 32'(5'b01000));
        drive(1'b0, ADDU, '0, '0);
        step();
        check("b2b_pulse", 32'(bus.done), 32'd0);

        // Reset in the 5th cycle of a MUL aborts it without a done pulse
        run_op("pre_rst", ADDU, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000);
        drive(1'b1, MUL, 16'd300, 16'd7);
        step();
        drive(1'b0, ADDU, '0, '0);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_res", 32'(bus.result), 32'd0);
        check("abort_flg", 32'(bus.flags), 32'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done || bus.busy) dones++;
        end
        check("abort_quiet", 32'(dones), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
